tt_um_micro_edge_counter: RTL

Parametrised multi-channel edge counter for the microtile slot, successor to the purely combinational 8-in/8-out Wokwi tiles. It adds a clock and reset, per-channel synchronisers, selectable rising-edge or both-edge counting, and saturate/wrap policy. A sticky overflow flag is kept per channel. The block uses the standard microtile pin set (ui_in/uo_out) plus clk/rst_n and is exercised by the same style of pin-level wrapper bench.

---
 rtl/tt_micro_pkg.sv | 20 ++
 rtl/tt_um_micro_edge_counter_if.sv | 8 +
 rtl/micro_sync_edge.sv | 31 +++
 rtl/tt_um_micro_edge_counter.sv | 101 ++++++++++
 4 files changed

// File: rtl/tt_micro_pkg.sv
// Shared pin map, counting mode and legal parameter ranges for the microtile
// edge counter.
package tt_micro_pkg;
  localparam int CH_LSB   = 0;
  localparam int SEL_LSB  = 4;
  localparam int MODE_BIT = 6;
  localparam int CLR_BIT  = 7;

  typedef enum logic {
    MODE_RISE = 1'b0,
    MODE_BOTH = 1'b1
  } mode_e;

  localparam int CHANNELS_MIN = 1;
  localparam int CHANNELS_MAX = 4;
  localparam int WIDTH_MIN    = 4;
  localparam int WIDTH_MAX    = 7;
  localparam int SYNC_MIN     = 2;
  localparam int SYNC_MAX     = 3;
endpackage

// File: rtl/tt_um_micro_edge_counter_if.sv
// Microtile pin bundle: 8 inputs in, 8 outputs back.
interface tt_um_micro_edge_counter_if;
  logic [7:0] ui_in;
  logic [7:0] uo_out;

  modport master (output ui_in, input uo_out);
  modport slave  (input ui_in, output uo_out);
endinterface

// File: rtl/micro_sync_edge.sv
// One input bit: synchroniser chain, previous-value flop and arm-gated
// rising / any-edge strobes.
module micro_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  input  logic armed,
  output logic rise,
  output logic any
);
  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;
  logic                   s;

  assign s = chain[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
      prev  <= s;
    end
  end

  assign rise = armed & s & ~prev;
  assign any  = armed & (s ^ prev);
endmodule

// File: rtl/tt_um_micro_edge_counter.sv
// Multi-channel edge counter: synchronised inputs, per-channel counters with
// sticky overflow, per-channel clear and a combinational display mux.
module tt_um_micro_edge_counter
  import tt_micro_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 7,
  parameter int SYNC_STAGES = 2,
  parameter bit SATURATE    = 1'b1
) (
  input logic clk,
  input logic rst_n,
  tt_um_micro_edge_counter_if.slave pins
);
  if (CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_MAX ||
      WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX ||
      SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_param
    $error("tt_um_micro_edge_counter: parameter out of legal range");
  end

  localparam int               CTL_W    = 8 - SEL_LSB;
  localparam int               ARM_DONE = SYNC_STAGES + 1;
  localparam logic [WIDTH-1:0] CNT_MAX  = '1;

  logic [SYNC_STAGES-1:0][CTL_W-1:0] ctl_chain;
  logic [CTL_W-1:0]                  ctl_s;
  logic [1:0]                        sel_s;
  logic                              clr_s;
  mode_e                             mode;
  logic [2:0]                        arm_cnt;
  logic                              armed;
  logic [CHANNELS-1:0]               rise, any, hit;
  logic [CHANNELS-1:0][WIDTH-1:0]    cnt;
  logic [CHANNELS-1:0]               ovf;
  logic [7:0]                        uo;

  // Select/mode/clear bits share the channel synchroniser depth so that a
  // clear lines up with an edge driven in the same input cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) ctl_chain <= '0;
    else        ctl_chain <= {ctl_chain[SYNC_STAGES-2:0], pins.ui_in[7:SEL_LSB]};
  end

  assign ctl_s = ctl_chain[SYNC_STAGES-1];
  assign sel_s = ctl_s[1:0];
  assign mode  = mode_e'(ctl_s[MODE_BIT-SEL_LSB]);
  assign clr_s = ctl_s[CLR_BIT-SEL_LSB];

  // Edges stay masked until the chains have flushed, so a level held
  // through reset never looks like an edge.
  assign armed = (arm_cnt == 3'(ARM_DONE));

  always_ff @(posedge clk) begin
    if (!rst_n)      arm_cnt <= '0;
    else if (!armed) arm_cnt <= arm_cnt + 3'd1;
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    micro_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (pins.ui_in[CH_LSB+c]),
      .armed (armed),
      .rise  (rise[c]),
      .any   (any[c])
    );
  end

  assign hit = (mode == MODE_BOTH) ? any : rise;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      ovf <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (clr_s && int'(sel_s) == c) begin
          cnt[c] <= '0;
          ovf[c] <= 1'b0;
        end else if (hit[c]) begin
          if (cnt[c] != CNT_MAX) begin
            cnt[c] <= cnt[c] + 1'b1;
          end else begin
            ovf[c] <= 1'b1;
            if (!SATURATE) cnt[c] <= '0;
          end
        end
      end
    end
  end

  // Display follows the raw select pins with no latency.
  always_comb begin
    uo = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (int'(pins.ui_in[SEL_LSB+:2]) == c) uo = {ovf[c], 7'(cnt[c])};
    end
  end

  assign pins.uo_out = uo;
endmodule
